// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment digit interface: segment patterns
// (common with the encoder side) and the receive-side sequence states.
package seg7_pkg;

    // bit0 = seg1 (top) .. bit6 = seg7 (middle)
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SEEN     = 2'd1,
        LOCKED   = 2'd2
    } mon_state_t;

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder; only the exact table forms
// are valid, the all-off pattern is reported separately as blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        blank = 1'b0;
        digit = 4'd0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// Receive-side monitor for the seconds-digit segment bus: synchronise, filter,
// decode, check 0..9 sequencing and measure the spacing between digits.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [6:0]          segments_in,
    input  logic                clear,
    output logic [3:0]          digit_out,
    output logic                digit_valid,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                locked,
    output logic                pattern_err,
    output logic                seq_err
);

    localparam int HOLD_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(STABLE_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_CYCLES - 1);

    logic [6:0]          seg_meta_reg, seg_sync_reg;
    logic [6:0]          cand_reg, accepted_reg, accepted_next;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    mon_state_t          state_reg, state_next;
    logic [3:0]          digit_reg, digit_next;
    logic                dv_reg, dv_next, pv_reg, pv_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic [PERIOD_W-1:0] cnt_reg, cnt_next;
    logic                pattern_err_reg, pattern_err_next;
    logic                seq_err_reg, seq_err_next;
    logic                accept;
    logic                dec_valid, dec_blank;
    logic [3:0]          dec_digit;

    // Data path of the synchroniser carries no reset.
    always_ff @(posedge clk) begin
        seg_meta_reg <= segments_in;
        seg_sync_reg <= seg_meta_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_reg     <= SEG_BLANK;
            hold_cnt_reg <= '0;
        end else if (seg_sync_reg != cand_reg) begin
            cand_reg     <= seg_sync_reg;
            hold_cnt_reg <= '0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    // Fires once per candidate, on the edge that completes STABLE_CYCLES of hold.
    assign accept = (seg_sync_reg == cand_reg) && (hold_cnt_reg == HOLD_HIT) &&
                    (cand_reg != accepted_reg);

    seg7_decode u_decode (
        .pattern (cand_reg),
        .valid   (dec_valid),
        .blank   (dec_blank),
        .digit   (dec_digit)
    );

    always_comb begin
        state_next       = state_reg;
        accepted_next    = accepted_reg;
        digit_next       = digit_reg;
        dv_next          = 1'b0;
        pv_next          = 1'b0;
        period_next      = period_reg;
        pattern_err_next = pattern_err_reg & ~clear;
        seq_err_next     = seq_err_reg & ~clear;

        if (accept) begin
            accepted_next = cand_reg;
            if (dec_blank) begin
                state_next = UNLOCKED;
            end else if (!dec_valid) begin
                pattern_err_next = 1'b1;
                state_next       = UNLOCKED;
            end else begin
                digit_next = dec_digit;
                dv_next    = 1'b1;
                case (state_reg)
                    UNLOCKED: state_next = SEEN;
                    default: begin
                        if (dec_digit == next_digit(digit_reg)) begin
                            state_next  = LOCKED;
                            pv_next     = 1'b1;
                            period_next = cnt_reg;
                        end else begin
                            seq_err_next = 1'b1;
                            state_next   = SEEN;
                        end
                    end
                endcase
            end
        end

        if (clear) begin
            state_next = UNLOCKED;
        end
    end

    always_comb begin
        if (clear) begin
            cnt_next = '0;
        end else if (accept && dec_valid) begin
            cnt_next = PERIOD_W'(1);
        end else if (cnt_reg != {PERIOD_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= UNLOCKED;
            accepted_reg    <= SEG_BLANK;
            digit_reg       <= 4'd0;
            dv_reg          <= 1'b0;
            pv_reg          <= 1'b0;
            period_reg      <= '0;
            cnt_reg         <= '0;
            pattern_err_reg <= 1'b0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            accepted_reg    <= accepted_next;
            digit_reg       <= digit_next;
            dv_reg          <= dv_next;
            pv_reg          <= pv_next;
            period_reg      <= period_next;
            cnt_reg         <= cnt_next;
            pattern_err_reg <= pattern_err_next;
            seq_err_reg     <= seq_err_next;
        end
    end

    assign digit_out    = digit_reg;
    assign digit_valid  = dv_reg;
    assign period_out   = period_reg;
    assign period_valid = pv_reg;
    assign locked       = (state_reg == LOCKED);
    assign pattern_err  = pattern_err_reg;
    assign seq_err      = seq_err_reg;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: latency, glitch rejection, sequencing,
// error flags, clear, period saturation and asynchronous reset.
module tb_seg7_monitor;
    import seg7_pkg::*;

    localparam int PW = 12;

    logic          clk;
    logic          reset_n;
    logic [6:0]    segments_in;
    logic          clear;
    logic [3:0]    digit_out;
    logic          digit_valid;
    logic [PW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          pattern_err;
    logic          seq_err;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt, pv_cnt, pv_alone, lat;
    logic [6:0] seg_tab [10];
    int seqd [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

    seg7_monitor #(.STABLE_CYCLES(4), .PERIOD_W(PW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .segments_in  (segments_in),
        .clear        (clear),
        .digit_out    (digit_out),
        .digit_valid  (digit_valid),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .pattern_err  (pattern_err),
        .seq_err      (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n, input int exp_period);
        segments_in = p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (digit_valid) dv_cnt++;
            if (period_valid) begin
                pv_cnt++;
                if (!digit_valid) pv_alone++;
                check("period_out_on_pulse", 32'(period_out), 32'(exp_period));
            end
        end
    endtask

    task automatic zero_counts();
        dv_cnt   = 0;
        pv_cnt   = 0;
        pv_alone = 0;
    endtask

    initial begin
        seg_tab = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
        reset_n     = 1'b0;
        segments_in = SEG_BLANK;
        clear       = 1'b0;
        zero_counts();

        repeat (3) @(posedge clk);
        #1;
        check("rst_digit_out", 32'(digit_out), 0);
        check("rst_digit_valid", 32'(digit_valid), 0);
        check("rst_period_out", 32'(period_out), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_flags", 32'({pattern_err, seq_err}), 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: first digit latency
        lat = 0;
        segments_in = SEG_0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (digit_valid) begin
                dv_cnt++;
                if (lat == 0) lat = i;
            end
            if (period_valid) pv_cnt++;
        end
        check("t1_latency", 32'(lat), 6);
        check("t1_dv_pulses", 32'(dv_cnt), 1);
        check("t1_digit_out", 32'(digit_out), 0);
        check("t1_locked", 32'(locked), 0);
        check("t1_pv_pulses", 32'(pv_cnt), 0);

        // 2: short pulse is filtered out
        zero_counts();
        hold(SEG_1, 3, 0);
        hold(SEG_0, 12, 0);
        check("t2_dv_pulses", 32'(dv_cnt), 0);
        check("t2_flags", 32'({pattern_err, seq_err}), 0);
        check("t2_digit_out", 32'(digit_out), 0);

        // 3: clean 0..9,0,1 sequence at 100-cycle spacing
        hold(SEG_BLANK, 20, 0);
        check("t3_blank_unlocked", 32'(locked), 0);
        zero_counts();
        hold(SEG_0, 100, 100);
        check("t3_locked_after_0", 32'(locked), 0);
        for (int k = 0; k < 11; k++) hold(seg_tab[seqd[k]], 100, 100);
        check("t3_pv_pulses", 32'(pv_cnt), 11);
        check("t3_dv_pulses", 32'(dv_cnt), 12);
        check("t3_pv_without_dv", 32'(pv_alone), 0);
        check("t3_seq_err", 32'(seq_err), 0);
        check("t3_locked", 32'(locked), 1);
        check("t3_digit_out", 32'(digit_out), 1);
        check("t3_period_out", 32'(period_out), 100);

        // 4: out-of-sequence digits then relock
        hold(SEG_3, 100, 100);
        check("t4_seq_err", 32'(seq_err), 1);
        check("t4_unlocked", 32'(locked), 0);
        hold(SEG_5, 100, 100);
        check("t4_still_unlocked", 32'(locked), 0);
        hold(SEG_6, 100, 100);
        check("t4_relocked", 32'(locked), 1);
        check("t4_period_out", 32'(period_out), 100);
        check("t4_digit_out", 32'(digit_out), 6);

        // 5: alternate 6 form is a pattern error; clear wipes flags
        hold(7'b1111101, 20, 0);
        check("t5_pattern_err", 32'(pattern_err), 1);
        check("t5_unlocked", 32'(locked), 0);
        check("t5_digit_hold", 32'(digit_out), 6);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("t5_clear_flags", 32'({pattern_err, seq_err}), 0);
        check("t5_clear_digit_hold", 32'(digit_out), 6);
        check("t5_clear_period_hold", 32'(period_out), 100);

        // 6: period counter saturates, then async reset
        zero_counts();
        hold(SEG_2, (1 << PW) + 10, 0);
        hold(SEG_3, 20, (1 << PW) - 1);
        check("t6_pv_pulses", 32'(pv_cnt), 1);
        check("t6_period_sat", 32'(period_out), 32'((1 << PW) - 1));
        check("t6_locked", 32'(locked), 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_arst_digit_out", 32'(digit_out), 0);
        check("t6_arst_period_out", 32'(period_out), 0);
        check("t6_arst_locked", 32'(locked), 0);
        check("t6_arst_pulses", 32'({digit_valid, period_valid}), 0);
        check("t6_arst_flags", 32'({pattern_err, seq_err}), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
